calc_sequencer: RTL and testbench

- Input-side stage of the calculator, sitting directly upstream of the 4-bit ALU.
- Accepts keypad events one per handshake: operand A, then operator, then operand B.
- Holds the registered operands and operator on the ALU inputs (i1, i2, ctrl) for a settle window, then captures the ALU output o into a result register.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_sequencer.sv | 129 ++++++++++++
 tb/tb_calc_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator input sequencer and its ALU neighbour.
// Operator codes are the ALU's ctrl encoding; the sequencer only forwards them.
package calc_pkg;

    localparam int CALC_W      = 4;
    localparam int CALC_CTRL_W = 2;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } ctrl_t;

endpackage

// File: rtl/calc_sequencer.sv
// Keypad-to-ALU sequencer: collects A, operator, B, holds them on the ALU for SETTLE cycles, captures alu_o.
// Build option: define CALC_CHAIN_EN to let an operator key after a result chain from that result.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W      = CALC_W,
    parameter int CTRL_W = CALC_CTRL_W,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic              key_is_op,
    input  logic [W-1:0]      key_val,
    input  logic              key_clr,
    output logic [W-1:0]      alu_i1,
    output logic [W-1:0]      alu_i2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [W-1:0]      alu_o,
    output logic [W-1:0]      result,
    output logic              result_valid,
    output logic              busy,
    output state_t            dbg_state_o
);

    localparam int CNT_W = 4;

    state_t              state_q;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic [W-1:0]        result_q;
    logic                result_valid_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                accept;

    // Handshake: a key event is consumed on a rising edge where key_valid && key_ready.
    // key_ready depends only on the state register, never on key inputs.
    assign key_ready = (state_q != S_EXEC);
    assign accept    = key_valid && key_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_A;
            a_q            <= '0;
            b_q            <= '0;
            ctrl_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            result_valid_q <= 1'b0;
            if (key_clr) begin
                state_q  <= S_A;
                a_q      <= '0;
                b_q      <= '0;
                ctrl_q   <= '0;
                result_q <= '0;
                cnt_q    <= '0;
            end else begin
                case (state_q)
                    S_A: begin
                        if (accept && !key_is_op) begin
                            a_q     <= key_val;
                            state_q <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (accept) begin
                            if (key_is_op) begin
                                ctrl_q  <= key_val[CTRL_W-1:0];
                                state_q <= S_B;
                            end else begin
                                a_q <= key_val;
                            end
                        end
                    end
                    S_B: begin
                        if (accept) begin
                            if (key_is_op) begin
                                ctrl_q <= key_val[CTRL_W-1:0];
                            end else begin
                                b_q     <= key_val;
                                cnt_q   <= CNT_W'(SETTLE - 1);
                                state_q <= S_EXEC;
                            end
                        end
                    end
                    S_EXEC: begin
                        // Operands stay frozen on the ALU until the count runs out.
                        if (cnt_q == '0) begin
                            result_q       <= alu_o;
                            result_valid_q <= 1'b1;
                            state_q        <= S_SHOW;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    S_SHOW: begin
                        if (accept) begin
                            if (!key_is_op) begin
                                a_q     <= key_val;
                                b_q     <= '0;
                                state_q <= S_OP;
                            end else begin
`ifdef CALC_CHAIN_EN
                                a_q     <= result_q;
                                ctrl_q  <= key_val[CTRL_W-1:0];
                                state_q <= S_B;
`endif
                            end
                        end
                    end
                    default: state_q <= S_A;
                endcase
            end
        end
    end

    assign alu_i1       = a_q;
    assign alu_i2       = b_q;
    assign alu_ctrl     = ctrl_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q == S_EXEC);
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: one instance with SETTLE=1 and one with SETTLE=4, each fed by a modelled ALU.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic       clk;
  logic       rst;
  logic       key_valid    [2];
  logic       key_ready    [2];
  logic       key_is_op    [2];
  logic [3:0] key_val      [2];
  logic       key_clr      [2];
  logic [3:0] alu_i1       [2];
  logic [3:0] alu_i2       [2];
  logic [1:0] alu_ctrl     [2];
  logic [3:0] alu_o        [2];
  logic [3:0] alu_ovr      [2];
  logic       alu_force    [2];
  logic [3:0] result       [2];
  logic       result_valid [2];
  logic       busy         [2];
  state_t     st           [2];

  int total;
  int bad;
  bit sb_en;
  logic [3:0] exp_q[$];

  calc_sequencer #(.W(4), .CTRL_W(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst),
    .key_valid(key_valid[0]), .key_ready(key_ready[0]), .key_is_op(key_is_op[0]),
    .key_val(key_val[0]), .key_clr(key_clr[0]),
    .alu_i1(alu_i1[0]), .alu_i2(alu_i2[0]), .alu_ctrl(alu_ctrl[0]), .alu_o(alu_o[0]),
    .result(result[0]), .result_valid(result_valid[0]), .busy(busy[0]), .dbg_state_o(st[0])
  );

  calc_sequencer #(.W(4), .CTRL_W(2), .SETTLE(4)) dut4 (
    .clk(clk), .rst(rst),
    .key_valid(key_valid[1]), .key_ready(key_ready[1]), .key_is_op(key_is_op[1]),
    .key_val(key_val[1]), .key_clr(key_clr[1]),
    .alu_i1(alu_i1[1]), .alu_i2(alu_i2[1]), .alu_ctrl(alu_ctrl[1]), .alu_o(alu_o[1]),
    .result(result[1]), .result_valid(result_valid[1]), .busy(busy[1]), .dbg_state_o(st[1])
  );

  // Behavioural 4-bit ALU: the environment the sequencer drives.
  function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c);
    case (c)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      alu_o[d] = alu_force[d] ? alu_ovr[d] : ref_alu(alu_i1[d], alu_i2[d], alu_ctrl[d]);
    end
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard on result_valid pulses of the SETTLE=1 instance
  always @(negedge clk) begin
    if (sb_en && result_valid[0]) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: result_valid with result=%0d, required no pulse", result[0]);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (result[0] !== e) begin
          bad++;
          $display("FAIL sb_result: got %0d required %0d", result[0], e);
        end
      end
    end
  end

  // driver tasks
  task automatic send_key(input int d, input bit op, input logic [3:0] v);
    int n;
    n = 0;
    @(negedge clk);
    key_valid[d] = 1'b1;
    key_is_op[d] = op;
    key_val[d]   = v;
    while (!key_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!key_ready[d]) begin
      bad++;
      $display("FAIL key_accept dut%0d: key_ready=0 required 1", d);
    end
    @(posedge clk);
    #1;
    key_valid[d] = 1'b0;
  endtask

  task automatic pulse_clr(input int d);
    @(negedge clk);
    key_clr[d] = 1'b1;
    @(posedge clk);
    #1;
    key_clr[d] = 1'b0;
  endtask

  // Called just after the B-accept edge: result_valid must stay low for n-1 edges, then be seen high.
  task automatic wait_result(input int d, input int n, input logic [3:0] exp);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (k < n) begin
        if (result_valid[d] !== 1'b0) begin
          bad++;
          $display("FAIL early_valid dut%0d edge %0d: result_valid=%b required 0", d, k, result_valid[d]);
        end
      end else if (result_valid[d] !== 1'b1 || result[d] !== exp) begin
        bad++;
        $display("FAIL capture dut%0d: valid=%b result=%0d required valid=1 result=%0d",
                 d, result_valid[d], result[d], exp);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (result_valid[d] !== 1'b0 || result[d] !== exp || st[d] !== S_SHOW) begin
      bad++;
      $display("FAIL show_hold dut%0d: valid=%b result=%0d state=%0d required 0/%0d/S_SHOW",
               d, result_valid[d], result[d], st[d], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (st[d] !== S_A || alu_i1[d] !== 4'd0 || alu_i2[d] !== 4'd0 || alu_ctrl[d] !== 2'd0 ||
          result[d] !== 4'd0 || result_valid[d] !== 1'b0 || busy[d] !== 1'b0 || key_ready[d] !== 1'b1) begin
        bad++;
        $display("FAIL reset dut%0d: state=%0d i1=%0d i2=%0d ctrl=%0d res=%0d rv=%b busy=%b rdy=%b required all 0, rdy=1",
                 d, st[d], alu_i1[d], alu_i2[d], alu_ctrl[d], result[d], result_valid[d], busy[d], key_ready[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_key(0, 1'b0, 4'd6);
    send_key(0, 1'b1, 4'd1);
    send_key(0, 1'b0, 4'd2);
    total++;
    if (alu_i1[0] !== 4'd6 || alu_i2[0] !== 4'd2 || alu_ctrl[0] !== 2'b01 || busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL basic_operands: i1=%0d i2=%0d ctrl=%0d busy=%b required 6/2/1/1",
               alu_i1[0], alu_i2[0], alu_ctrl[0], busy[0]);
    end
    wait_result(0, 1, ref_alu(4'd6, 4'd2, 2'b01));
  endtask

  task automatic test_last_entry();
    send_key(1, 1'b0, 4'd3);
    send_key(1, 1'b0, 4'd5);
    send_key(1, 1'b1, 4'd0);
    send_key(1, 1'b0, 4'd1);
    total++;
    if (alu_i1[1] !== 4'd5 || alu_i2[1] !== 4'd1 || busy[1] !== 1'b1 || key_ready[1] !== 1'b0) begin
      bad++;
      $display("FAIL last_entry: i1=%0d i2=%0d busy=%b rdy=%b required 5/1/1/0",
               alu_i1[1], alu_i2[1], busy[1], key_ready[1]);
    end
    key_valid[1] = 1'b1;
    key_is_op[1] = 1'b0;
    key_val[1]   = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    key_valid[1] = 1'b0;
    total++;
    if (alu_i1[1] !== 4'd5 || alu_i2[1] !== 4'd1 || busy[1] !== 1'b1 || key_ready[1] !== 1'b0) begin
      bad++;
      $display("FAIL exec_reject: i1=%0d i2=%0d busy=%b rdy=%b required 5/1/1/0",
               alu_i1[1], alu_i2[1], busy[1], key_ready[1]);
    end
    wait_result(1, 2, ref_alu(4'd5, 4'd1, 2'b00));
  endtask

  task automatic test_settle();
    logic [3:0] fin;
    fin = 4'($urandom_range(1, 15));
    send_key(1, 1'b0, 4'd2);
    send_key(1, 1'b1, 4'd3);
    send_key(1, 1'b0, 4'd7);
    alu_force[1] = 1'b1;
    alu_ovr[1]   = fin ^ 4'($urandom_range(1, 15));
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (k < 4 && result_valid[1] !== 1'b0) begin
        bad++;
        $display("FAIL settle_early edge %0d: result_valid=%b required 0", k, result_valid[1]);
      end else if (k == 4 && (result_valid[1] !== 1'b1 || result[1] !== fin)) begin
        bad++;
        $display("FAIL settle_capture: valid=%b result=%0d required 1/%0d", result_valid[1], result[1], fin);
      end
      if (k < 3) alu_ovr[1] = fin ^ 4'($urandom_range(1, 15));
      else       alu_ovr[1] = fin;
    end
    alu_force[1] = 1'b0;
  endtask

  task automatic test_clr_exec();
    bit seen;
    send_key(1, 1'b0, 4'd1);
    send_key(1, 1'b1, 4'd2);
    send_key(1, 1'b0, 4'd4);
    @(posedge clk);
    #1;
    key_clr[1]   = 1'b1;
    key_valid[1] = 1'b1;
    key_is_op[1] = 1'b0;
    key_val[1]   = 4'd3;
    @(posedge clk);
    #1;
    key_clr[1]   = 1'b0;
    key_valid[1] = 1'b0;
    total++;
    if (st[1] !== S_A || result[1] !== 4'd0 || alu_i1[1] !== 4'd0 || alu_i2[1] !== 4'd0 ||
        alu_ctrl[1] !== 2'd0 || result_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
      bad++;
      $display("FAIL clr_exec: state=%0d res=%0d i1=%0d i2=%0d ctrl=%0d rv=%b busy=%b required S_A and zeros",
               st[1], result[1], alu_i1[1], alu_i2[1], alu_ctrl[1], result_valid[1], busy[1]);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (result_valid[1]) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL clr_no_pulse: result_valid seen=1 required 0");
    end
    send_key(1, 1'b0, 4'd9);
    total++;
    if (alu_i1[1] !== 4'd9 || st[1] !== S_OP) begin
      bad++;
      $display("FAIL clr_restart: i1=%0d state=%0d required 9/S_OP", alu_i1[1], st[1]);
    end
  endtask

  task automatic test_async_rst();
    send_key(0, 1'b0, 4'd4);
    send_key(0, 1'b1, 4'd1);
    total++;
    if (st[0] !== S_B || result[0] !== 4'd4) begin
      bad++;
      $display("FAIL pre_rst: state=%0d result=%0d required S_B/4", st[0], result[0]);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (st[0] !== S_A || alu_i1[0] !== 4'd0 || alu_i2[0] !== 4'd0 || alu_ctrl[0] !== 2'd0 ||
        result[0] !== 4'd0 || result_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: state=%0d i1=%0d i2=%0d ctrl=%0d res=%0d rv=%b busy=%b required S_A and zeros",
               st[0], alu_i1[0], alu_i2[0], alu_ctrl[0], result[0], result_valid[0], busy[0]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_chain();
    send_key(0, 1'b0, 4'd6);
    send_key(0, 1'b1, 4'd1);
    send_key(0, 1'b0, 4'd2);
    wait_result(0, 1, 4'd4);
    send_key(0, 1'b1, 4'b1100);
`ifdef CALC_CHAIN_EN
    total++;
    if (st[0] !== S_B || alu_i1[0] !== 4'd4 || alu_ctrl[0] !== 2'b00) begin
      bad++;
      $display("FAIL chain_op: state=%0d i1=%0d ctrl=%0d required S_B/4/0", st[0], alu_i1[0], alu_ctrl[0]);
    end
    send_key(0, 1'b0, 4'd2);
    wait_result(0, 1, 4'd6);
    total++;
    if (alu_i1[0] !== 4'd4 || alu_i2[0] !== 4'd2) begin
      bad++;
      $display("FAIL chain_operands: i1=%0d i2=%0d required 4/2", alu_i1[0], alu_i2[0]);
    end
`else
    total++;
    if (st[0] !== S_SHOW || alu_i1[0] !== 4'd6 || alu_ctrl[0] !== 2'b01 || result[0] !== 4'd4) begin
      bad++;
      $display("FAIL show_op_ignored: state=%0d i1=%0d ctrl=%0d res=%0d required S_SHOW/6/1/4",
               st[0], alu_i1[0], alu_ctrl[0], result[0]);
    end
    send_key(0, 1'b0, 4'd2);
    total++;
    if (st[0] !== S_OP || alu_i1[0] !== 4'd2 || alu_i2[0] !== 4'd0 || result[0] !== 4'd4) begin
      bad++;
      $display("FAIL show_new_calc: state=%0d i1=%0d i2=%0d res=%0d required S_OP/2/0/4",
               st[0], alu_i1[0], alu_i2[0], result[0]);
    end
`endif
  endtask

  // Random calculations: a calc is defined by the last digit before the first operator,
  // the last operator before the next digit, and that digit.
  task automatic test_random();
    logic [3:0] a, b, v;
    logic [1:0] c;
    int n;
    sb_en = 1'b1;
    for (int it = 0; it < 25; it++) begin
      pulse_clr(0);
      repeat ($urandom_range(0, 2)) send_key(0, 1'b1, 4'($urandom));
      repeat ($urandom_range(1, 3)) begin
        a = 4'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_key(0, 1'b0, a);
      end
      repeat ($urandom_range(1, 3)) begin
        v = 4'($urandom);
        c = v[1:0];
        send_key(0, 1'b1, v);
      end
      b = 4'($urandom);
      exp_q.push_back(ref_alu(a, b, c));
      send_key(0, 1'b0, b);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL rand_timeout it %0d: pending=%0d required 0", it, exp_q.size());
        exp_q.delete();
      end
      total++;
      if (alu_i1[0] !== a || alu_i2[0] !== b || alu_ctrl[0] !== c) begin
        bad++;
        $display("FAIL rand_operands it %0d: i1=%0d i2=%0d ctrl=%0d required %0d/%0d/%0d",
                 it, alu_i1[0], alu_i2[0], alu_ctrl[0], a, b, c);
      end
    end
    repeat (3) @(negedge clk);
    sb_en = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sb_en = 1'b0;
    rst   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      key_valid[d] = 1'b0;
      key_is_op[d] = 1'b0;
      key_val[d]   = 4'd0;
      key_clr[d]   = 1'b0;
      alu_ovr[d]   = 4'd0;
      alu_force[d] = 1'b0;
    end
    test_reset();
    test_basic();
    test_last_entry();
    test_settle();
    test_clr_exec();
    test_async_rst();
    test_chain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
